// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: issues PC to synchronous imem, splits the returned word into decode fields.
// Latency: 2 edges from address issue to valid_out; taken jump redirects combinationally, 2-slot penalty.
// Backpressure: stall holds PC and IF/ID and re-reads the in-flight word; a taken jump overrides stall.
module fetch_stage #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [PC_WIDTH-1:0]  PC_STEP     = PC_WIDTH'(4)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   JumpI,
    input  logic                   JumpCI,
    input  logic                   JumpCD,
    input  logic                   zero_flag,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   redirect,
    output logic                   valid_out,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [1:0]             instruction_type,
    output logic [1:0]             func,
    output logic                   imm,
    output logic                   vector,
    output logic [INSTR_WIDTH-7:0] instr_body
);

    logic                   taken;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    f_pc;
    logic                   f_valid;
    logic [INSTR_WIDTH-1:0] id_instr;
    logic [PC_WIDTH-1:0]    id_pc;
    logic                   id_valid;

    assign taken    = JumpI | (JumpCI & zero_flag) | (JumpCD & ~zero_flag);
    assign redirect = taken;

    // On stall the word currently returning would be dropped, so re-issue its address.
    always_comb begin
        imem_addr = pc;
        if (taken) begin
            imem_addr = branch_target;
        end else if (stall) begin
            imem_addr = f_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            f_pc     <= RESET_PC;
            f_valid  <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (taken) begin
            pc       <= branch_target + PC_STEP;
            f_pc     <= branch_target;
            f_valid  <= 1'b1;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_instr <= imem_rdata;
            id_pc    <= f_pc;
            id_valid <= f_valid;
            f_pc     <= pc;
            f_valid  <= 1'b1;
            pc       <= pc + PC_STEP;
        end
    end

    // Invalid slots present all-zero fields; consumers must still qualify with valid_out.
    assign valid_out        = id_valid;
    assign pc_out           = id_pc;
    assign instruction_type = id_valid ? id_instr[INSTR_WIDTH-1:INSTR_WIDTH-2] : 2'b00;
    assign func             = id_valid ? id_instr[INSTR_WIDTH-3:INSTR_WIDTH-4] : 2'b00;
    assign imm              = id_valid & id_instr[INSTR_WIDTH-5];
    assign vector           = id_valid & id_instr[INSTR_WIDTH-6];
    assign instr_body       = id_valid ? id_instr[INSTR_WIDTH-7:0] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stream-level reference model, random stall/jump stimulus, wrap instance.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] imem_addr, imem_rdata, branch_target, pc_out;
    logic        stall, JumpI, JumpCI, JumpCD, zero_flag;
    logic        redirect, valid_out, imm, vector;
    logic [1:0]  instruction_type, func;
    logic [25:0] instr_body;

    logic [31:0] w_addr, w_rdata, w_pc_out, w_tgt;
    logic        w_zero, w_redirect, w_valid, w_imm, w_vector;
    logic [1:0]  w_type, w_func;
    logic [25:0] w_body;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          rd;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // Stream-level model: which PC appears next, and whether a warm-up slot is still owed.
    logic [31:0] m_next;
    bit          m_warm;
    bit          m_valid;
    logic [31:0] m_pc;

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .JumpI(JumpI), .JumpCI(JumpCI), .JumpCD(JumpCD),
        .zero_flag(zero_flag), .branch_target(branch_target), .redirect(redirect),
        .valid_out(valid_out), .pc_out(pc_out), .instruction_type(instruction_type),
        .func(func), .imm(imm), .vector(vector), .instr_body(instr_body)
    );

    assign w_zero = 1'b0;
    assign w_tgt  = 32'h0;

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .stall(w_zero), .JumpI(w_zero), .JumpCI(w_zero), .JumpCD(w_zero),
        .zero_flag(w_zero), .branch_target(w_tgt), .redirect(w_redirect),
        .valid_out(w_valid), .pc_out(w_pc_out), .instruction_type(w_type),
        .func(w_func), .imm(w_imm), .vector(w_vector), .instr_body(w_body)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    always @(posedge clk) imem_rdata <= memf(imem_addr);
    always @(posedge clk) w_rdata    <= memf(w_addr);

    task automatic model_reset();
        m_next  = 32'h0;
        m_warm  = 1'b1;
        m_valid = 1'b0;
        m_pc    = 32'h0;
    endtask

    // Drive one cycle of inputs, record what the DUT must show this cycle, then advance the model.
    task automatic apply(input bit st, input bit ji, input bit jci, input bit jcd,
                         input bit zf, input logic [31:0] tgt);
        exp_t e;
        bit   jump;
        stall = st; JumpI = ji; JumpCI = jci; JumpCD = jcd;
        zero_flag = zf; branch_target = tgt;
        jump = ji || (jci && zf) || (jcd && !zf);
        e.v = m_valid; e.pc = m_pc; e.rd = jump;
        q.push_back(e);
        if (jump) begin
            m_valid = 1'b0;
            m_warm  = 1'b0;
            m_next  = tgt;
        end else if (!st) begin
            if (m_warm) begin
                m_warm  = 1'b0;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_pc    = m_next;
                m_next  = m_next + 32'd4;
            end
        end
    endtask

    task automatic cyc(input bit st, input bit ji, input bit jci, input bit jcd,
                       input bit zf, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        apply(st, ji, jci, jcd, zf, tgt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            int unsigned r;
            logic [31:0] tgt;
            r   = $urandom_range(0, 15);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom;
            cyc($urandom_range(0, 3) == 0, r == 0, r == 1, r == 2, $urandom_range(0, 1) == 1, tgt);
        end
    endtask

    task automatic chk_reset(input string name);
        logic [63:0] outs;
        outs = {31'h0, redirect, valid_out, pc_out} | {28'h0, instruction_type, func, imm, vector, instr_body, 6'h0};
        tests++;
        if (outs !== 64'h0) begin
            fails++;
            $display("FAIL %s outputs: got %h, want 0", name, outs);
        end
        tests++;
        if (imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL %s imem_addr: got %h, want 0", name, imem_addr);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [31:0] got_f, want_f;
            mon_e  = q.pop_front();
            got_f  = {instruction_type, func, imm, vector, instr_body};
            want_f = mon_e.v ? memf(mon_e.pc) : 32'h0;
            tests++;
            if (redirect !== mon_e.rd) begin
                fails++;
                $display("FAIL redirect: got %b, want %b", redirect, mon_e.rd);
            end
            tests++;
            if (valid_out !== mon_e.v) begin
                fails++;
                $display("FAIL valid_out: got %b, want %b (pc %h)", valid_out, mon_e.v, mon_e.pc);
            end
            tests++;
            if (got_f !== want_f) begin
                fails++;
                $display("FAIL fields: got %h, want %h", got_f, want_f);
            end
            if (mon_e.v) begin
                tests++;
                if (pc_out !== mon_e.pc) begin
                    fails++;
                    $display("FAIL pc_out: got %h, want %h", pc_out, mon_e.pc);
                end
            end
        end
    end

    // Wrap instance: two empty slots after release, then FFFFFFF8, FFFFFFFC, 00000000.
    initial begin
        @(posedge rst);
        for (int k = 0; k < 5; k++) begin
            logic [32:0] want, got;
            @(negedge clk);
            want = (k < 2) ? 33'h0 : {1'b1, 32'hFFFF_FFF8 + 32'(4 * (k - 2))};
            got  = (k < 2) ? {w_valid, 32'h0} : {w_valid, w_pc_out};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL wrap slot %0d: got %h, want %h", k, got, want);
            end
            if (k >= 2) begin
                tests++;
                if ({w_type, w_func, w_imm, w_vector, w_body} !== memf(want[31:0])) begin
                    fails++;
                    $display("FAIL wrap fields %0d: got %h, want %h", k,
                             {w_type, w_func, w_imm, w_vector, w_body}, memf(want[31:0]));
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        stall = 0; JumpI = 0; JumpCI = 0; JumpCD = 0; zero_flag = 0; branch_target = 32'h0;
        model_reset();
        #3;
        chk_reset("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 32'h0);
        idle(3);
        repeat (3) cyc(1, 0, 0, 0, 0, 32'h0);
        idle(2);
        cyc(0, 1, 0, 0, 0, 32'h100);
        idle(4);
        cyc(0, 0, 1, 0, 0, 32'h700);
        idle(3);
        cyc(0, 0, 0, 1, 0, 32'h800);
        idle(4);
        cyc(1, 1, 0, 0, 0, 32'h2000);
        idle(4);
        cyc(1, 0, 0, 1, 1, 32'h3000);
        cyc(1, 0, 1, 0, 1, 32'h4000);
        idle(3);
        rand_cycles(400);

        @(negedge clk);
        #1;
        rst = 1'b0;
        stall = 0; JumpI = 0; JumpCI = 0; JumpCD = 0; zero_flag = 0; branch_target = 32'h0;
        #1;
        chk_reset("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 32'h0);
        rand_cycles(200);
        idle(2);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
